lc3_state_dump: RTL and testbench
=================================

# lc3_state_dump

Debug-readout stage directly downstream of the LC-3 processor top. On a `start` pulse it snapshots PC, IR and NZP, then walks the register-file debug read port (`SR_r`/`Out_r`) and the memory direct read port (`address_in_direct`/`mem_out_direct`). It serialises everything as a framed 16-bit valid/ready word stream for a host link, such as a UART or JTAG bridge.

## Interface

Parameters:
- `HEADER`, default 16'hD00D: first word of every frame.
- `READ_LAT`, default 1: cycles from a stable read address to valid read data on `Out_r` and `mem_out_direct`.

Ports:
- `clk` in 1: the single clock. `clk_r` and `clk_direct` of the processor are tied to `clk` at the top level.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request. Accepted only when `busy`=0.
- `mem_base` in 16: first memory address to dump. Sampled on an accepted `start`.
- `mem_count` in 16: number of memory words to dump. Sampled on an accepted `start`. 0 means no memory words.
- `PC` in 16: processor PC.
- `IR` in 16: processor IR.
- `N`, `Z`, `P` in 1 each: processor condition codes.
- `SR_r` out 3: register-file debug read select.
- `Out_r` in 16: register-file debug read data.
- `address_in_direct` out 16: memory direct read address.
- `mem_out_direct` in 16: memory direct read data.
- `dout_data` out 16: stream word.
- `dout_valid` out 1: stream word valid.
- `dout_last` out 1: marks the final word of the frame.
- `dout_ready` in 1: sink accepts the word.
- `busy` out 1: high from the accepted `start` until the last word is accepted.
- `done` out 1: one-cycle pulse after the last handshake.

## Operation

Frame order is fixed:
1. `HEADER`
2. PC snapshot
3. IR snapshot
4. {13'b0, N, Z, P} snapshot
5. R0 through R7
6. `mem_count` words from `mem_base` upward

- Frame length is 12 + `mem_count` words. The counter is 17 bits wide so `mem_count`=16'hFFFF does not overflow.
- Memory address increments mod 2^16: 16'hFFFF wraps to 16'h0000.
- The PC, IR and NZP snapshot is taken on the accepting `start` edge. Later changes on those inputs do not alter the frame.
- State machine:
  - IDLE → HDR on `start`.
  - HDR → SNAP. SNAP runs 3 words.
  - SNAP → RADDR.
  - RADDR drives `SR_r`, holds it for `READ_LAT` cycles, captures `Out_r`, then goes to RSEND.
  - RSEND → RADDR while the register index is < 7.
  - After R7: → MADDR if `mem_count` ≠ 0, else → IDLE.
  - MADDR/MSEND follow the same pattern as RADDR/RSEND using `address_in_direct` and `mem_out_direct`.
  - → IDLE after the last accepted word.
- Every SEND-type state asserts `dout_valid` and waits for `dout_ready`.
- `dout_last` is asserted together with the final word: R7 when `mem_count`=0, otherwise the last memory word.
- `start` while `busy` is ignored, with no queueing.
- `SR_r` and `address_in_direct` stay stable throughout their capture window. They hold their last value while idle.

## Timing

- Reset values: `SR_r`=0, `address_in_direct`=0, `dout_data`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `done`=0. All internal counters and snapshots are cleared.
- `busy` rises on the cycle after the `start` edge.
- `HEADER` is valid on that same cycle.
- Handshake: a word transfers on a rising edge where `dout_valid` and `dout_ready` are both high.
  - While `dout_valid` is high and `dout_ready` is low, `dout_data` and `dout_last` are held constant.
  - `dout_valid` never drops without a transfer, except on reset.
- Snapshot words go out back-to-back: 1 word per cycle when `dout_ready`=1.
- Register and memory words go out at 1 word per (`READ_LAT` + 1) cycles when `dout_ready`=1.
- `done` pulses on the cycle after the last transfer. `busy` falls on that same cycle.
- A `start` on the same cycle `done` is high is accepted.
- Reset mid-frame: the frame is abandoned with no `dout_last`. On the next cycle all outputs take their reset values.

## Structure

- Package `lc3_dump_pkg` holds:
  - the state enum: IDLE, HDR, SNAP, RADDR, RSEND, MADDR, MSEND;
  - `SNAP_WORDS`=3;
  - `NUM_REGS`=8;
  - the default `HEADER`.
- Single module. The output holding register (data, valid, last) is kept inline; it is not a separate sub-module.

## Test plan

- Reset asserted mid-idle for 2 cycles → all outputs 0, `busy`=0, no `dout_valid`.
- Preload R0..R7 = 16'h1000..16'h1007, PC=16'h3000, IR=16'h1021, NZP=010. Then `start` with `mem_count`=0 and `dout_ready`=1 → stream D00D, 3000, 1021, 0002, 1000..1007. `dout_last` is set on 1007 only. `done` pulses once.
- `mem_base`=16'hFFFE, `mem_count`=3 → `address_in_direct` goes FFFE, FFFF, 0000. 15 words total. `dout_last` is set on the word read from 0000.
- Random `dout_ready` at 30% duty → `dout_data` and `dout_last` never change while stalled. The sequence is identical to the `dout_ready`=1 run.
- Change PC and R3 after `start`, plus a second `start` while `busy` → frame carries the pre-`start` PC. Only one frame is produced. The second `start` is ignored.
- Assert `reset` during the memory phase → on the next cycle `dout_valid`=0 and `busy`=0. A subsequent `start` yields a complete, correct frame.

Source files
------------

// File: rtl/lc3_dump_pkg.sv
// Shared types and constants for the LC-3 state dump frame generator.
package lc3_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SNAP,
        RADDR,
        RSEND,
        MADDR,
        MSEND
    } dump_state_e;

    localparam int unsigned SNAP_WORDS     = 3;
    localparam int unsigned NUM_REGS       = 8;
    localparam logic [15:0] DEFAULT_HEADER = 16'hD00D;

    // Words in every frame before the memory section: header, snapshot, registers.
    localparam int unsigned FIXED_WORDS = 1 + SNAP_WORDS + NUM_REGS;

    function automatic logic [15:0] snap_word(input logic [1:0]  idx,
                                              input logic [15:0] pc,
                                              input logic [15:0] ir,
                                              input logic [2:0]  nzp);
        logic [15:0] w;
        case (idx)
            2'd0:    w = pc;
            2'd1:    w = ir;
            default: w = {13'b0, nzp};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lc3_state_dump.sv
// Snapshots LC-3 PC/IR/NZP, walks the register file and a memory window,
// and emits the result as a framed valid/ready 16-bit word stream.
module lc3_state_dump
    import lc3_dump_pkg::*;
#(
    parameter logic [15:0] HEADER   = DEFAULT_HEADER,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] mem_base,
    input  logic [15:0] mem_count,
    input  logic [15:0] PC,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    output logic [2:0]  SR_r,
    input  logic [15:0] Out_r,
    output logic [15:0] address_in_direct,
    input  logic [15:0] mem_out_direct,
    output logic [15:0] dout_data,
    output logic        dout_valid,
    output logic        dout_last,
    input  logic        dout_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned      LAT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LAT - 1);
    localparam logic [2:0]       REG_LAST  = 3'(NUM_REGS - 1);
    localparam logic [1:0]       SNAP_LAST = 2'(SNAP_WORDS - 1);

    dump_state_e      state_q;
    logic [15:0]      dout_data_q;
    logic             dout_valid_q;
    logic             dout_last_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       sr_q;
    logic [15:0]      addr_q;
    logic [15:0]      pc_q;
    logic [15:0]      ir_q;
    logic [2:0]       nzp_q;
    logic [15:0]      mem_base_q;
    logic [1:0]       snap_idx_q;
    logic [LAT_W-1:0] lat_q;
    logic [16:0]      words_left_q;
    logic [16:0]      words_left_d;
    logic             xfer;
    logic             final_xfer;
    logic             lat_done;

    assign xfer         = dout_valid_q & dout_ready;
    assign final_xfer   = xfer && (words_left_q == 17'd1);
    assign lat_done     = (lat_q == LAT_LAST);
    assign words_left_d = xfer ? (words_left_q - 17'd1) : words_left_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dout_data_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sr_q         <= '0;
            addr_q       <= '0;
            pc_q         <= '0;
            ir_q         <= '0;
            nzp_q        <= '0;
            mem_base_q   <= '0;
            snap_idx_q   <= '0;
            lat_q        <= '0;
            words_left_q <= '0;
        end else begin
            done_q       <= 1'b0;
            words_left_q <= words_left_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        pc_q         <= PC;
                        ir_q         <= IR;
                        nzp_q        <= {N, Z, P};
                        mem_base_q   <= mem_base;
                        words_left_q <= 17'(FIXED_WORDS) + {1'b0, mem_count};
                        dout_data_q  <= HEADER;
                        dout_valid_q <= 1'b1;
                        dout_last_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        snap_idx_q  <= '0;
                        dout_data_q <= snap_word(2'd0, pc_q, ir_q, nzp_q);
                        state_q     <= SNAP;
                    end
                end
                SNAP: begin
                    if (xfer) begin
                        if (snap_idx_q == SNAP_LAST) begin
                            sr_q         <= '0;
                            lat_q        <= '0;
                            dout_valid_q <= 1'b0;
                            state_q      <= RADDR;
                        end else begin
                            snap_idx_q  <= snap_idx_q + 2'd1;
                            dout_data_q <= snap_word(snap_idx_q + 2'd1, pc_q, ir_q, nzp_q);
                        end
                    end
                end
                // Read address is held stable for READ_LAT cycles before capture.
                RADDR, MADDR: begin
                    if (lat_done) begin
                        dout_data_q  <= (state_q == RADDR) ? Out_r : mem_out_direct;
                        dout_valid_q <= 1'b1;
                        dout_last_q  <= (words_left_q == 17'd1);
                        state_q      <= (state_q == RADDR) ? RSEND : MSEND;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                RSEND, MSEND: begin
                    if (final_xfer) begin
                        dout_valid_q <= 1'b0;
                        dout_last_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= IDLE;
                    end else if (xfer) begin
                        dout_valid_q <= 1'b0;
                        lat_q        <= '0;
                        if (state_q == MSEND) begin
                            addr_q  <= addr_q + 16'd1;
                            state_q <= MADDR;
                        end else if (sr_q == REG_LAST) begin
                            addr_q  <= mem_base_q;
                            state_q <= MADDR;
                        end else begin
                            sr_q    <= sr_q + 3'd1;
                            state_q <= RADDR;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign SR_r              = sr_q;
    assign address_in_direct = addr_q;
    assign dout_data         = dout_data_q;
    assign dout_valid        = dout_valid_q;
    assign dout_last         = dout_last_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_lc3_state_dump.sv
// Scoreboard bench for lc3_state_dump: expected frames are queued before start
// and popped as words are accepted on the stream.
module tb_lc3_state_dump;

    localparam logic [15:0] HDR_WORD = 16'hD00D;
    localparam logic [15:0] MEM_XOR  = 16'h5A5A;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] mem_base;
    logic [15:0] mem_count;
    logic [15:0] PC;
    logic [15:0] IR;
    logic        N, Z, P;
    logic [2:0]  SR_r;
    logic [15:0] Out_r;
    logic [15:0] address_in_direct;
    logic [15:0] mem_out_direct;
    logic [15:0] dout_data;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ready = 1'b0;
    logic        busy;
    logic        done;

    logic [15:0] regs [8];
    logic [16:0] exp_q [$];
    int          ready_pct = 100;
    int          n_assert  = 0;
    int          n_fail    = 0;
    int          done_cnt  = 0;
    int          busy_cyc  = 0;
    logic        stall_pend = 1'b0;
    logic [15:0] held_data  = '0;
    logic        held_last  = 1'b0;

    always #5 clk = ~clk;

    assign Out_r          = regs[SR_r];
    assign mem_out_direct = address_in_direct ^ MEM_XOR;

    always @(posedge clk) begin
        #1 dout_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end

    lc3_state_dump #(.HEADER(HDR_WORD), .READ_LAT(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .mem_base          (mem_base),
        .mem_count         (mem_count),
        .PC                (PC),
        .IR                (IR),
        .N                 (N),
        .Z                 (Z),
        .P                 (P),
        .SR_r              (SR_r),
        .Out_r             (Out_r),
        .address_in_direct (address_in_direct),
        .mem_out_direct    (mem_out_direct),
        .dout_data         (dout_data),
        .dout_valid        (dout_valid),
        .dout_last         (dout_last),
        .dout_ready        (dout_ready),
        .busy              (busy),
        .done              (done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [15:0] pc, input logic [15:0] ir,
                              input logic [2:0] nzp, input logic [15:0] base,
                              input logic [15:0] cnt);
        logic [15:0] a;
        exp_q.push_back({1'b0, HDR_WORD});
        exp_q.push_back({1'b0, pc});
        exp_q.push_back({1'b0, ir});
        exp_q.push_back({1'b0, 13'b0, nzp});
        for (int r = 0; r < 8; r++)
            exp_q.push_back({(cnt == 16'd0 && r == 7), regs[r]});
        a = base;
        for (int m = 0; m < int'(cnt); m++) begin
            exp_q.push_back({(m == int'(cnt) - 1), a ^ MEM_XOR});
            a = a + 16'd1;
        end
    endtask

    // One bench cycle: sample at the falling edge, check stall hold and accepted word.
    task automatic mon_cycle();
        logic [16:0] e;
        @(negedge clk);
        if (stall_pend) begin
            n_assert++;
            if (dout_valid !== 1'b1 || dout_data !== held_data || dout_last !== held_last) begin
                n_fail++;
                $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                         dout_valid, dout_data, dout_last, held_data, held_last);
            end
        end
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: data=%h last=%b, required no word", dout_data, dout_last);
            end else begin
                e = exp_q.pop_front();
                if ({dout_last, dout_data} !== e) begin
                    n_fail++;
                    $display("FAIL stream_word: data=%h last=%b, required data=%h last=%b",
                             dout_data, dout_last, e[15:0], e[16]);
                end
            end
        end
        stall_pend = (dout_valid === 1'b1 && dout_ready !== 1'b1);
        held_data  = dout_data;
        held_last  = dout_last;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cyc++;
    endtask

    task automatic drain_frame(input int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            mon_cycle();
            cyc++;
        end
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_timeout: outstanding=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) mon_cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        mon_cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) mon_cycle();
        reset = 1'b0;
        repeat (3) mon_cycle();
        reset = 1'b1;
        repeat (2) mon_cycle();
        n_assert++;
        if ({dout_valid, dout_last, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/last/busy/done=%b, required 0000",
                     {dout_valid, dout_last, busy, done});
        end
        n_assert++;
        if (dout_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: dout_data=%h, required 0000", dout_data);
        end
        n_assert++;
        if (SR_r !== 3'd0 || address_in_direct !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_addr: SR_r=%0d addr=%h, required 0 and 0000", SR_r, address_in_direct);
        end
        reset = 1'b0;
        mon_cycle();
        n_assert++;
        if (dout_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b busy=%b, required 0 0", dout_valid, busy);
        end
    endtask

    task automatic test_regs_only();
        int d0, b0;
        for (int r = 0; r < 8; r++) regs[r] = 16'h1000 + 16'(r);
        PC = 16'h3000; IR = 16'h1021; {N, Z, P} = 3'b010;
        mem_base = 16'h0040; mem_count = 16'd0;
        push_frame(16'h3000, 16'h1021, 3'b010, 16'h0040, 16'd0);
        d0 = done_cnt; b0 = busy_cyc;
        pulse_start();
        n_assert++;
        if (busy !== 1'b1 || dout_valid !== 1'b1 || dout_data !== HDR_WORD) begin
            n_fail++;
            $display("FAIL start_response: busy=%b valid=%b data=%h, required 1 1 %h",
                     busy, dout_valid, dout_data, HDR_WORD);
        end
        drain_frame(500);
        n_assert++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL regs_done_pulses: %0d, required 1", done_cnt - d0);
        end
        n_assert++;
        if (busy_cyc - b0 != 20) begin
            n_fail++;
            $display("FAIL regs_busy_cycles: %0d, required 20", busy_cyc - b0);
        end
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL regs_busy_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_mem_wrap();
        int d0, b0;
        PC = 16'h3100; IR = 16'h5020; {N, Z, P} = 3'b100;
        mem_base = 16'hFFFE; mem_count = 16'd3;
        push_frame(16'h3100, 16'h5020, 3'b100, 16'hFFFE, 16'd3);
        n_assert++;
        if (exp_q.size() != 15) begin
            n_fail++;
            $display("FAIL wrap_frame_len: %0d, required 15", exp_q.size());
        end
        d0 = done_cnt; b0 = busy_cyc;
        pulse_start();
        drain_frame(500);
        n_assert++;
        if (address_in_direct !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_final_addr: %h, required 0000", address_in_direct);
        end
        n_assert++;
        if (busy_cyc - b0 != 26) begin
            n_fail++;
            $display("FAIL wrap_busy_cycles: %0d, required 26", busy_cyc - b0);
        end
        n_assert++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL wrap_done_pulses: %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_random_ready();
        int d0;
        ready_pct = 30;
        mon_cycle();
        PC = 16'h3200; IR = 16'h0E05; {N, Z, P} = 3'b001;
        mem_base = 16'h0100; mem_count = 16'd4;
        push_frame(16'h3200, 16'h0E05, 3'b001, 16'h0100, 16'd4);
        d0 = done_cnt;
        pulse_start();
        drain_frame(3000);
        ready_pct = 100;
        mon_cycle();
        n_assert++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL random_done_pulses: %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_busy_ignore();
        int d0;
        ready_pct = 0;
        repeat (2) mon_cycle();
        PC = 16'h3000; IR = 16'h1021; {N, Z, P} = 3'b010;
        mem_base = 16'h0000; mem_count = 16'd0;
        d0 = done_cnt;
        pulse_start();
        PC = 16'h4444; IR = 16'hFFFF; {N, Z, P} = 3'b100;
        regs[3] = 16'hBEEF;
        mem_count = 16'd2;
        push_frame(16'h3000, 16'h1021, 3'b010, 16'h0000, 16'd0);
        mon_cycle();
        pulse_start();
        ready_pct = 100;
        drain_frame(500);
        repeat (30) mon_cycle();
        n_assert++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL ignore_done_pulses: %0d, required 1", done_cnt - d0);
        end
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_busy_end: busy=%b, required 0", busy);
        end
        regs[3] = 16'h1003;
    endtask

    task automatic test_back_to_back();
        int d0;
        int cyc = 0;
        mem_base = 16'h0010; mem_count = 16'd0;
        push_frame(16'h3300, 16'h2222, 3'b001, 16'h0010, 16'd0);
        push_frame(16'h3400, 16'h3333, 3'b100, 16'h0010, 16'd1);
        PC = 16'h3300; IR = 16'h2222; {N, Z, P} = 3'b001;
        d0 = done_cnt;
        pulse_start();
        while (done !== 1'b1 && cyc < 500) begin
            mon_cycle();
            cyc++;
        end
        n_assert++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_done: done=%b, required 1", done);
        end
        PC = 16'h3400; IR = 16'h3333; {N, Z, P} = 3'b100; mem_count = 16'd1;
        pulse_start();
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_accept: busy=%b, required 1", busy);
        end
        drain_frame(500);
        n_assert++;
        if (done_cnt - d0 != 2) begin
            n_fail++;
            $display("FAIL b2b_done_pulses: %0d, required 2", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        PC = 16'h3500; IR = 16'h6040; {N, Z, P} = 3'b010;
        mem_base = 16'h0200; mem_count = 16'd5;
        push_frame(16'h3500, 16'h6040, 3'b010, 16'h0200, 16'd5);
        pulse_start();
        while (exp_q.size() > 2 && cyc < 500) begin
            mon_cycle();
            cyc++;
        end
        reset = 1'b1;
        mon_cycle();
        reset = 1'b0;
        exp_q.delete();
        n_assert++;
        if (dout_valid !== 1'b0 || busy !== 1'b0 || dout_last !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: valid=%b busy=%b last=%b done=%b, required 0 0 0 0",
                     dout_valid, busy, dout_last, done);
        end
        n_assert++;
        if (dout_data !== 16'h0000 || address_in_direct !== 16'h0000 || SR_r !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_data: data=%h addr=%h SR_r=%0d, required 0000 0000 0",
                     dout_data, address_in_direct, SR_r);
        end
        mon_cycle();
        PC = 16'h3600; IR = 16'h7777; {N, Z, P} = 3'b001;
        mem_base = 16'h0300; mem_count = 16'd2;
        push_frame(16'h3600, 16'h7777, 3'b001, 16'h0300, 16'd2);
        pulse_start();
        drain_frame(500);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        mem_base = '0; mem_count = '0; PC = '0; IR = '0;
        N = 1'b0; Z = 1'b0; P = 1'b0;
        for (int r = 0; r < 8; r++) regs[r] = 16'h1000 + 16'(r);
        test_reset();
        test_regs_only();
        test_mem_wrap();
        test_random_ready();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
